// File: rtl/enemy_fire_scheduler_if.sv
// Shot-request handshake between the enemy fire scheduler and the enemy
// munition.
//   fire_valid : scheduler -> munition, a shot request is pending
//   fire_ack   : munition -> scheduler, the pending shot is accepted
//   id_col     : selected shooter column (4 bits)
//   id_row     : selected shooter row (3 bits)
//   id_enemy   : id_row*COLUNAS + id_col (7 bits)
interface enemy_fire_scheduler_if;
    logic       fire_valid;
    logic       fire_ack;
    logic [3:0] id_col;
    logic [2:0] id_row;
    logic [6:0] id_enemy;

    modport master (
        output fire_valid, id_col, id_row, id_enemy,
        input  fire_ack
    );

    modport slave (
        input  fire_valid, id_col, id_row, id_enemy,
        output fire_ack
    );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler. Every PERIOD enabled, non-busy cycles it scans the
// enemy grid column by column, starting at a rotating column pointer, picks
// the bottom-most live enemy of the first non-empty column and requests a
// shot from the munition until it is accepted or the shooter dies.
//   clk, reset    : clock, synchronous active-high reset
//   enable        : game running
//   vivo_inimigo  : alive map, bit k*COLUNAS+i = row k, column i
//   shot_busy     : an enemy bullet is in flight (freezes the timer)
//   fire          : shot-request handshake (master side)
//   no_target     : one-cycle pulse when a full scan found nobody alive
//   shots_fired   : accepted shots, saturating at 255
module enemy_fire_scheduler #(
    parameter int LINHAS  = 5,
    parameter int COLUNAS = 13,
    parameter int PERIOD  = 10_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [LINHAS*COLUNAS-1:0]   vivo_inimigo,
    input  logic                        shot_busy,
    enemy_fire_scheduler_if.master      fire,
    output logic                        no_target,
    output logic [7:0]                  shots_fired
);
    localparam int COL_W   = 4;
    localparam int ROW_W   = 3;
    localparam int ENEMY_W = 7;
    localparam logic [23:0]      TIMER_LAST = 24'(PERIOD - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLUNAS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REQ} state_t;

    state_t               state_q, state_d;
    logic [23:0]          timer_q, timer_d;
    logic [COL_W-1:0]     col_ptr_q, col_ptr_d;
    logic [COL_W-1:0]     scan_col_q, scan_col_d;
    logic [COL_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [COL_W-1:0]     id_col_q, id_col_d;
    logic [ROW_W-1:0]     id_row_q, id_row_d;
    logic [ENEMY_W-1:0]   id_enemy_q, id_enemy_d;
    logic                 no_target_q, no_target_d;
    logic [7:0]           shots_fired_q, shots_fired_d;

    logic                 col_hit;
    logic [ROW_W-1:0]     hit_row;
    logic [ENEMY_W-1:0]   hit_enemy;
    logic                 tgt_alive;

    function automatic logic [COL_W-1:0] inc_col(input logic [COL_W-1:0] c);
        return (c == LAST_COL) ? '0 : c + 4'd1;
    endfunction

    // Grid lookups with constant bit indices only. Rows are visited in
    // ascending order so the last hit is the bottom-most live enemy.
    always_comb begin
        col_hit   = 1'b0;
        hit_row   = '0;
        tgt_alive = 1'b0;
        for (int k = 0; k < LINHAS; k++) begin
            for (int i = 0; i < COLUNAS; i++) begin
                if (COL_W'(i) == scan_col_q && vivo_inimigo[k*COLUNAS+i]) begin
                    col_hit = 1'b1;
                    hit_row = ROW_W'(k);
                end
                if (COL_W'(i) == id_col_q && ROW_W'(k) == id_row_q && vivo_inimigo[k*COLUNAS+i])
                    tgt_alive = 1'b1;
            end
        end
        hit_enemy = ENEMY_W'(hit_row) * ENEMY_W'(COLUNAS) + ENEMY_W'(scan_col_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            col_ptr_q     <= '0;
            scan_col_q    <= '0;
            scan_cnt_q    <= '0;
            id_col_q      <= '0;
            id_row_q      <= '0;
            id_enemy_q    <= '0;
            no_target_q   <= 1'b0;
            shots_fired_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            col_ptr_q     <= col_ptr_d;
            scan_col_q    <= scan_col_d;
            scan_cnt_q    <= scan_cnt_d;
            id_col_q      <= id_col_d;
            id_row_q      <= id_row_d;
            id_enemy_q    <= id_enemy_d;
            no_target_q   <= no_target_d;
            shots_fired_q <= shots_fired_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        col_ptr_d     = col_ptr_q;
        scan_col_d    = scan_col_q;
        scan_cnt_d    = scan_cnt_q;
        id_col_d      = id_col_q;
        id_row_d      = id_row_q;
        id_enemy_d    = id_enemy_q;
        no_target_d   = 1'b0;
        shots_fired_d = shots_fired_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !shot_busy) begin
                    if (timer_q == TIMER_LAST) begin
                        state_d    = S_SCAN;
                        timer_d    = '0;
                        scan_col_d = col_ptr_q;
                        scan_cnt_d = '0;
                    end else begin
                        timer_d = timer_q + 24'd1;
                    end
                end
            end
            S_SCAN: begin
                if (col_hit) begin
                    id_col_d   = scan_col_q;
                    id_row_d   = hit_row;
                    id_enemy_d = hit_enemy;
                    state_d    = S_REQ;
                end else if (scan_cnt_q == LAST_COL) begin
                    // Whole grid empty: the rotation pointer stays put.
                    no_target_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    scan_col_d = inc_col(scan_col_q);
                    scan_cnt_d = scan_cnt_q + 4'd1;
                end
            end
            S_REQ: begin
                // An accepted shot beats a shooter that died the same cycle.
                if (fire.fire_ack) begin
                    col_ptr_d = inc_col(id_col_q);
                    if (shots_fired_q != 8'hFF)
                        shots_fired_d = shots_fired_q + 8'd1;
                    state_d = S_IDLE;
                end else if (!tgt_alive) begin
                    state_d    = S_SCAN;
                    scan_col_d = id_col_q;
                    scan_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!enable) begin
            state_d = S_IDLE;
            timer_d = '0;
        end
    end

    // Outputs
    always_comb begin
        fire.fire_valid = (state_q == S_REQ);
        fire.id_col     = id_col_q;
        fire.id_row     = id_row_q;
        fire.id_enemy   = id_enemy_q;
        no_target       = no_target_q;
        shots_fired     = shots_fired_q;
    end
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler with PERIOD=8 on a 5x13 grid.
module tb_enemy_fire_scheduler;
    localparam int L = 5;
    localparam int C = 13;
    localparam int P = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [L*C-1:0]   vivo;
    logic             shot_busy;
    logic             no_target;
    logic [7:0]       shots_fired;

    enemy_fire_scheduler_if fif ();

    enemy_fire_scheduler #(.LINHAS(L), .COLUNAS(C), .PERIOD(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .vivo_inimigo (vivo),
        .shot_busy    (shot_busy),
        .fire         (fif),
        .no_target    (no_target),
        .shots_fired  (shots_fired)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until fire_valid is seen high, bounded by max.
    task automatic wait_fv(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fif.fire_valid && n < max);
    endtask

    // Two reset edges; released in the region right after an edge.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [L*C-1:0] all_alive;
    int n, first_nt, last_nt, nt_cnt, fv_cnt, gap;

    initial begin
        reset = 1'b1; enable = 1'b0; vivo = '0; shot_busy = 1'b0; fif.fire_ack = 1'b0;
        all_alive = '1;

        // Reset state
        do_reset();
        chk("rst_fire_valid", 32'(fif.fire_valid), 0);
        chk("rst_id_col", 32'(fif.id_col), 0);
        chk("rst_id_row", 32'(fif.id_row), 0);
        chk("rst_id_enemy", 32'(fif.id_enemy), 0);
        chk("rst_no_target", 32'(no_target), 0);
        chk("rst_shots", 32'(shots_fired), 0);

        // All alive, ack tied high: two shots from columns 0 and 1
        vivo = all_alive; enable = 1'b1; fif.fire_ack = 1'b1;
        do_reset();
        wait_fv(40, n);
        chk("all_lat", n, 9);
        chk("all_col", 32'(fif.id_col), 0);
        chk("all_row", 32'(fif.id_row), 4);
        chk("all_enemy", 32'(fif.id_enemy), 52);
        wait_fv(40, n);
        chk("all2_lat", n, 10);
        chk("all2_enemy", 32'(fif.id_enemy), 53);
        tick();
        chk("all2_shots", 32'(shots_fired), 2);
        chk("all2_fv_low", 32'(fif.fire_valid), 0);
        fif.fire_ack = 1'b0;

        // Column 0 empty
        vivo = all_alive;
        for (int k = 0; k < L; k++) vivo[k*C] = 1'b0;
        do_reset();
        wait_fv(40, n);
        chk("c0e_lat", n, 10);
        chk("c0e_col", 32'(fif.id_col), 1);
        chk("c0e_enemy", 32'(fif.id_enemy), 53);

        // Only enemy 38 alive, then wrap of the column pointer to 0
        vivo = '0; vivo[38] = 1'b1;
        do_reset();
        wait_fv(60, n);
        chk("e38_lat", n, 21);
        chk("e38_enemy", 32'(fif.id_enemy), 38);
        chk("e38_row", 32'(fif.id_row), 2);
        chk("e38_col", 32'(fif.id_col), 12);
        fif.fire_ack = 1'b1;
        tick();
        fif.fire_ack = 1'b0;
        vivo = all_alive;
        wait_fv(40, n);
        chk("wrap_lat", n, 9);
        chk("wrap_enemy", 32'(fif.id_enemy), 52);

        // Empty grid: no_target every PERIOD+13 cycles, never a request
        vivo = '0;
        do_reset();
        first_nt = -1; last_nt = -1; nt_cnt = 0; fv_cnt = 0; gap = 0;
        for (int e = 1; e <= 64; e++) begin
            tick();
            if (fif.fire_valid) fv_cnt++;
            if (no_target) begin
                if (first_nt < 0) first_nt = e;
                else gap = e - last_nt;
                last_nt = e;
                nt_cnt++;
            end
        end
        chk("nt_first", 32'(first_nt), 21);
        chk("nt_count", 32'(nt_cnt), 3);
        chk("nt_gap", 32'(gap), 21);
        chk("nt_no_fv", 32'(fv_cnt), 0);

        // shot_busy freezes the timer for 100 cycles
        vivo = all_alive;
        do_reset();
        tick(); tick(); tick();
        shot_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fif.fire_valid) fv_cnt++;
        end
        chk("busy_no_fv", 32'(fv_cnt), 0);
        shot_busy = 1'b0;
        wait_fv(40, n);
        chk("busy_lat", n, 6);

        // Shooter dies in REQ, rescan picks row 3; enable drop; reset mid-REQ
        vivo = all_alive;
        do_reset();
        wait_fv(40, n);
        chk("die_enemy0", 32'(fif.id_enemy), 52);
        fif.fire_ack = 1'b0;
        tick(); tick();
        chk("die_hold_fv", 32'(fif.fire_valid), 1);
        chk("die_hold_enemy", 32'(fif.id_enemy), 52);
        chk("die_no_ack_shots", 32'(shots_fired), 0);
        vivo[52] = 1'b0;
        tick();
        chk("die_fv_drop", 32'(fif.fire_valid), 0);
        tick();
        chk("die_fv_rise", 32'(fif.fire_valid), 1);
        chk("die_row", 32'(fif.id_row), 3);
        chk("die_enemy", 32'(fif.id_enemy), 39);
        // ack and death in the same cycle: ack wins
        vivo[39] = 1'b0;
        fif.fire_ack = 1'b1;
        tick();
        fif.fire_ack = 1'b0;
        chk("prec_shots", 32'(shots_fired), 1);
        chk("prec_fv", 32'(fif.fire_valid), 0);
        vivo = all_alive;
        wait_fv(40, n);
        chk("prec_lat", n, 9);
        chk("prec_enemy", 32'(fif.id_enemy), 53);
        enable = 1'b0;
        tick();
        chk("en0_fv", 32'(fif.fire_valid), 0);
        chk("en0_shots", 32'(shots_fired), 1);
        enable = 1'b1;
        wait_fv(40, n);
        chk("en1_lat", n, 9);
        chk("en1_enemy", 32'(fif.id_enemy), 53);
        reset = 1'b1;
        tick();
        chk("midreq_rst_fv", 32'(fif.fire_valid), 0);
        chk("midreq_rst_shots", 32'(shots_fired), 0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
